song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL provide parameter NOTE_W, default 6, note code width.
REQ-002 SHALL provide parameter DUR_W, default 6, note duration width in beats.
REQ-003 SHALL provide parameter IDX_W, default 5, note index width (32 notes/song).
REQ-004 SHALL provide parameter SONG_W, default 2, song select width (4 songs).
REQ-005 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port play_button  input  1  one-cycle pulse, toggles play/pause.
REQ-008 SHALL have port next_button  input  1  one-cycle pulse, advances to next song.
REQ-009 SHALL have port beat  input  1  one-cycle tempo pulse.
REQ-010 SHALL have port rom_addr  output  SONG_W+IDX_W  registered song ROM address {song, idx}.
REQ-011 SHALL have port rom_data  input  NOTE_W+DUR_W  ROM word, {note, duration}, valid one cycle after rom_addr.
REQ-012 SHALL have port note_out  output  NOTE_W  current note to note player, 0 = rest.
REQ-013 SHALL have port note_load  output  1  one-cycle pulse, note_out newly valid.
REQ-014 SHALL have port play  output  1  high while playing.
REQ-015 SHALL have port song  output  SONG_W  current song number.
REQ-016 SHALL have port song_done  output  1  one-cycle pulse at end of song.

Function
REQ-017 SHALL implement states PAUSED, FETCH, LATCH, HOLD, END; all outputs registered.
REQ-018 FETCH SHALL drive rom_addr={song,idx} and go to LATCH next cycle.
REQ-019 LATCH SHALL sample rom_data; duration 0 -> END; else note_reg<=note, beats_left<=duration, note_load pulse, -> HOLD.
REQ-020 HOLD SHALL decrement beats_left on each beat; on beat with beats_left==1: idx==2^IDX_W-1 -> END, else idx<=idx+1 -> FETCH.
REQ-021 END SHALL pulse song_done one cycle, set idx<=0, beats_left<=0, play<=0, -> PAUSED; song unchanged.
REQ-022 play_button in PAUSED SHALL set play<=1; beats_left!=0 -> HOLD with note_load pulse (resume); else -> FETCH.
REQ-023 play_button in FETCH/LATCH/HOLD SHALL set play<=0 -> PAUSED, preserving idx and beats_left; in FETCH/LATCH beats_left<=0 so resume refetches the same idx.
REQ-024 play_button in END SHALL be ignored.
REQ-025 next_button in any state SHALL set song<=song+1 (wrap 3->0), idx<=0, beats_left<=0, play<=0, -> PAUSED.
REQ-026 next_button SHALL take priority over simultaneous play_button and beat.
REQ-027 beat SHALL be ignored outside HOLD; beat coincident with play_button in HOLD SHALL pause without decrementing.
REQ-028 note_out SHALL equal note_reg when play=1, else 0.
REQ-029 Latency: play_button at edge k from PAUSED with beats_left=0 -> rom_addr valid after k, note_load high in cycle after edge k+2.
REQ-030 note_load and song_done SHALL never be high for two consecutive cycles.

Reset
REQ-031 reset high SHALL immediately force PAUSED, song=0, idx=0, beats_left=0, rom_addr=0, note_out=0, note_load=0, play=0, song_done=0.
REQ-032 reset asserted mid-note SHALL abort playback; no note_load or song_done SHALL pulse on release.

Verification
REQ-033 Bench SHALL cover: reset, ROM[0]={note 9, dur 2}, play pulse -> rom_addr=0, note_load 3 edges later, note_out=9; two beats -> rom_addr=1.
REQ-034 Bench SHALL cover: ROM[0]=dur 3, play, one beat, play (pause) -> note_out=0, play=0; 5 beats ignored; play -> note_load, note_out restored, two more beats -> FETCH idx 1.
REQ-035 Bench SHALL cover: ROM[2]=dur 0 -> after note idx 1 ends, song_done one-cycle pulse, play=0, next play starts at rom_addr=0.
REQ-036 Bench SHALL cover: song=3, next_button -> song=0, play=0, rom_addr on next play = 0; next_button and play_button same cycle -> PAUSED, play stays 0.
REQ-037 Bench SHALL cover: all 32 notes dur 1 in song 1 -> 32 note_load pulses, song_done after 32nd beat, idx wraps to 0.
REQ-038 Bench SHALL cover: reset asserted during HOLD between clock edges -> outputs zero without clock edge, no pulses after release.

Source files
------------

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: button, tempo, song ROM and note player signals of the song sequencer
interface song_sequencer_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5,
  parameter int SONG_W = 2
);
  logic                      play_button;
  logic                      next_button;
  logic                      beat;
  logic [SONG_W+IDX_W-1:0]   rom_addr;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [NOTE_W-1:0]         note_out;
  logic                      note_load;
  logic                      play;
  logic [SONG_W-1:0]         song;
  logic                      song_done;
  // master drives buttons, tempo and ROM data; the sequencer is the slave
  modport master (
    output play_button, next_button, beat, rom_data,
    input  rom_addr, note_out, note_load, play, song, song_done
  );
  modport slave (
    input  play_button, next_button, beat, rom_data,
    output rom_addr, note_out, note_load, play, song, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: steps through {note, duration} words of a song ROM in time with a beat pulse
module song_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5,
  parameter int SONG_W = 2
) (
  input logic clk,
  input logic reset,
  song_sequencer_if.slave bus
);
  typedef enum logic [2:0] {PAUSED, FETCH, LATCH, HOLD, END} state_t;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [DUR_W-1:0]   beats_left;
  logic [NOTE_W-1:0]  note_reg;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;
  assign {rom_note, rom_dur} = bus.rom_data;
  // sequencer FSM; note_out is kept equal to play ? note_reg : 0 by updating it alongside play and note_reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= PAUSED;
      idx           <= '0;
      beats_left    <= '0;
      note_reg      <= '0;
      bus.rom_addr  <= '0;
      bus.note_out  <= '0;
      bus.note_load <= 1'b0;
      bus.play      <= 1'b0;
      bus.song      <= '0;
      bus.song_done <= 1'b0;
    end else begin
      bus.note_load <= 1'b0;
      bus.song_done <= 1'b0;
      if (bus.next_button) begin
        bus.song     <= bus.song + 1'b1;
        idx          <= '0;
        beats_left   <= '0;
        bus.play     <= 1'b0;
        bus.note_out <= '0;
        state        <= PAUSED;
      end else begin
        case (state)
          PAUSED: if (bus.play_button) begin
            bus.play     <= 1'b1;
            bus.note_out <= note_reg;
            if (beats_left != '0) begin
              bus.note_load <= 1'b1;
              state         <= HOLD;
            end else begin
              bus.rom_addr <= {bus.song, idx};
              state        <= FETCH;
            end
          end
          FETCH: if (bus.play_button) begin
            bus.play     <= 1'b0;
            bus.note_out <= '0;
            beats_left   <= '0;
            state        <= PAUSED;
          end else begin
            state <= LATCH;
          end
          LATCH: if (bus.play_button) begin
            bus.play     <= 1'b0;
            bus.note_out <= '0;
            beats_left   <= '0;
            state        <= PAUSED;
          end else if (rom_dur == '0) begin
            state <= END;
          end else begin
            note_reg      <= rom_note;
            bus.note_out  <= rom_note;
            beats_left    <= rom_dur;
            bus.note_load <= 1'b1;
            state         <= HOLD;
          end
          HOLD: if (bus.play_button) begin
            bus.play     <= 1'b0;
            bus.note_out <= '0;
            state        <= PAUSED;
          end else if (bus.beat) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == DUR_W'(1)) begin
              if (idx == LAST_IDX) begin
                state <= END;
              end else begin
                idx          <= idx + 1'b1;
                bus.rom_addr <= {bus.song, idx + 1'b1};
                state        <= FETCH;
              end
            end
          end
          END: begin
            bus.song_done <= 1'b1;
            idx           <= '0;
            beats_left    <= '0;
            bus.play      <= 1'b0;
            bus.note_out  <= '0;
            state         <= PAUSED;
          end
          default: state <= PAUSED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed and random checks of song_sequencer against a cycle-level player model
module tb_song_sequencer;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = 5;
  localparam int SONG_W = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  song_sequencer_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W)) bus ();
  song_sequencer #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  logic [11:0] rom [128];
  // synchronous song ROM: word appears one cycle after its address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  int checks = 0, failures = 0, loads = 0, dones = 0, l0, d0;
  bit         m_play, m_end, m_load, m_done;
  logic [1:0] m_song;
  logic [4:0] m_idx;
  logic [5:0] m_left, m_note, m_out;
  logic [6:0] m_addr;
  int         m_wait;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_play = 0; m_end = 0; m_load = 0; m_done = 0; m_song = 0; m_idx = 0;
    m_left = 0; m_note = 0; m_out = 0; m_addr = 0; m_wait = 0;
  endtask
  // m_wait counts edges until the fetched word is taken: 2 = address issued, 1 = data arriving
  task automatic model_step(input bit pb, input bit nb, input bit bt);
    logic [11:0] w;
    w = rom[{m_song, m_idx}];
    m_load = 0;
    m_done = 0;
    if (nb) begin
      m_song++; m_idx = 0; m_left = 0; m_play = 0; m_wait = 0; m_end = 0;
    end else if (m_end) begin
      m_done = 1; m_idx = 0; m_left = 0; m_play = 0; m_end = 0;
    end else if (!m_play) begin
      if (pb) begin
        m_play = 1;
        if (m_left != 0) m_load = 1;
        else begin m_wait = 2; m_addr = {m_song, m_idx}; end
      end
    end else if (pb) begin
      m_play = 0;
      if (m_wait != 0) m_left = 0;
      m_wait = 0;
    end else if (m_wait == 2) begin
      m_wait = 1;
    end else if (m_wait == 1) begin
      m_wait = 0;
      if (w[5:0] == 0) m_end = 1;
      else begin m_note = w[11:6]; m_left = w[5:0]; m_load = 1; end
    end else if (bt) begin
      m_left--;
      if (m_left == 0) begin
        if (m_idx == 31) m_end = 1;
        else begin m_idx++; m_wait = 2; m_addr = {m_song, m_idx}; end
      end
    end
    m_out = m_play ? m_note : 6'd0;
  endtask
  task automatic compare_all();
    chk("rom_addr", bus.rom_addr, m_addr);
    chk("note_out", bus.note_out, m_out);
    chk("note_load", bus.note_load, m_load);
    chk("play", bus.play, m_play);
    chk("song", bus.song, m_song);
    chk("song_done", bus.song_done, m_done);
  endtask
  task automatic tick(input bit pb, input bit nb, input bit bt);
    bus.play_button = pb;
    bus.next_button = nb;
    bus.beat = bt;
    @(posedge clk);
    model_step(pb, nb, bt);
    @(negedge clk);
    compare_all();
    if (bus.note_load) loads++;
    if (bus.song_done) dones++;
    bus.play_button = 0;
    bus.next_button = 0;
    bus.beat = 0;
  endtask
  initial begin
    bus.play_button = 0;
    bus.next_button = 0;
    bus.beat = 0;
    for (int i = 0; i < 128; i++) rom[i] = {6'($urandom_range(1, 63)), 6'd1};
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_addr", bus.rom_addr, 0);
    chk("reset_note", bus.note_out, 0);
    chk("reset_play", bus.play, 0);
    chk("reset_song", bus.song, 0);
    chk("reset_load", bus.note_load, 0);
    chk("reset_done", bus.song_done, 0);
    reset = 0;
    // first note, latency and advance to idx 1; idx 2 has zero duration and ends the song
    rom[0] = {6'd9, 6'd2};
    rom[1] = {6'd5, 6'd1};
    rom[2] = {6'd7, 6'd0};
    tick(1, 0, 0);
    chk("s1_addr0", bus.rom_addr, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("s1_load", bus.note_load, 1);
    chk("s1_note9", bus.note_out, 9);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("s1_addr1", bus.rom_addr, 1);
    d0 = dones;
    for (int i = 0; i < 20 && dones == d0; i++) tick(0, 0, 1);
    chk("s1_done_once", dones - d0, 1);
    chk("s1_play_off", bus.play, 0);
    tick(0, 0, 0);
    chk("s1_done_low", bus.song_done, 0);
    tick(1, 0, 0);
    chk("s1_restart_addr", bus.rom_addr, 0);
    tick(1, 0, 0);
    // pause mid-note, ignored beats, resume
    rom[0] = {6'd12, 6'd3};
    rom[1] = {6'd4, 6'd2};
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("s2_note12", bus.note_out, 12);
    tick(0, 0, 1);
    tick(1, 0, 0);
    chk("s2_pause_note", bus.note_out, 0);
    chk("s2_pause_play", bus.play, 0);
    l0 = loads;
    repeat (5) tick(0, 0, 1);
    chk("s2_no_load_paused", loads - l0, 0);
    tick(1, 0, 0);
    chk("s2_resume_load", bus.note_load, 1);
    chk("s2_resume_note", bus.note_out, 12);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("s2_fetch_idx1", bus.rom_addr, 1);
    tick(0, 1, 0);
    chk("s2_song1", bus.song, 1);
    // song 1: 32 one-beat notes
    l0 = loads;
    d0 = dones;
    tick(1, 0, 0);
    for (int i = 0; i < 300 && dones == d0; i++) tick(0, 0, 1);
    chk("s5_loads", loads - l0, 32);
    chk("s5_done", dones - d0, 1);
    tick(1, 0, 0);
    chk("s5_idx_wrap", bus.rom_addr, 32);
    tick(1, 0, 0);
    // song wrap and next_button priority
    tick(0, 1, 0);
    tick(0, 1, 0);
    chk("s4_song3", bus.song, 3);
    tick(0, 1, 0);
    chk("s4_wrap_song0", bus.song, 0);
    chk("s4_wrap_play", bus.play, 0);
    tick(1, 0, 0);
    chk("s4_addr0", bus.rom_addr, 0);
    tick(1, 1, 0);
    chk("s4_prio_song", bus.song, 1);
    chk("s4_prio_play", bus.play, 0);
    tick(0, 0, 0);
    // asynchronous reset in the middle of a held note
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("s6_holding", bus.play, 1);
    #2 reset = 1;
    #1;
    chk("s6_async_note", bus.note_out, 0);
    chk("s6_async_play", bus.play, 0);
    chk("s6_async_song", bus.song, 0);
    chk("s6_async_addr", bus.rom_addr, 0);
    chk("s6_async_load", bus.note_load, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    l0 = loads;
    d0 = dones;
    repeat (6) tick(0, 0, 1);
    chk("s6_no_load", loads - l0, 0);
    chk("s6_no_done", dones - d0, 0);
    // random ROM contents and button/beat traffic
    for (int i = 0; i < 128; i++)
      rom[i] = {6'($urandom_range(0, 63)), ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 4))};
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
